// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction prefetch queue with single outstanding fetch and redirect flush
// Optional feature: PREFETCH_BYPASS_EN presents an accepted response combinationally when the FIFO is empty.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          discard;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [AW:0]   count_next;

    assign mem_req  = (state == REQ);
    assign mem_addr = fetch_pc;

    // A response only lands if its request is still wanted: not flushed earlier and not flushed now.
    assign accept = (state == WAIT) && mem_rvalid && !discard && !redirect;
    assign pop    = (count != '0) && out_ready;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = accept && (count == '0);
    assign push      = accept && !(bypass && out_ready);
    assign out_valid = (count != '0) || bypass;
    assign out_instr = bypass ? mem_rdata : instr_mem[rd_ptr];
    assign out_pc    = bypass ? req_pc    : pc_mem[rd_ptr];
`else
    assign push      = accept;
    assign out_valid = (count != '0);
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
`endif

    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            discard  <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= mem_rdata;
                pc_mem[wr_ptr]    <= req_pc;
            end
            if (redirect) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= redirect_pc & ~32'd3;
                // A response returning in this same cycle closes the transaction, so nothing is left to discard.
                case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        if (mem_gnt) begin
                            state   <= WAIT;
                            discard <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (mem_rvalid) begin
                            state   <= REQ;
                            discard <= 1'b0;
                        end else begin
                            discard <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                count <= count_next;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case (state)
                    IDLE: begin
                        if (count_next < DEPTH_C) state <= REQ;
                    end
                    REQ: begin
                        if (mem_gnt) begin
                            state    <= WAIT;
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                    end
                    WAIT: begin
                        if (mem_rvalid) begin
                            discard <= 1'b0;
                            state   <= (count_next < DEPTH_C) ? REQ : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - self-checking bench for if_prefetch_queue
module tb_if_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: the instruction queue as the core should see it, plus the one in-flight fetch.
    logic [31:0] q_pc[$];
    logic [31:0] q_data[$];
    logic [31:0] exp_pc;
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_addr;

    // Memory responder
    bit          gnt_en;
    int          lat;
    bit          mem_pend;
    int          mem_wait;
    logic [31:0] mem_pend_addr;
    bit          stray_rv;

    logic [31:0] pop_log[$];
    logic [31:0] pop_data_log[$];
    int          pop_cyc[$];
    logic [31:0] gnt_log[$];

    logic [31:0] s1_pc   [4] = '{32'h0000_3000, 32'h0000_3004, 32'h0000_3008, 32'h0000_300C};
    logic [31:0] s1_data [4] = '{32'hFFFF_CFFF, 32'hFFFF_CFFB, 32'hFFFF_CFF7, 32'hFFFF_CFF3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic model_reset();
        q_pc.delete();
        q_data.delete();
        exp_pc = RESET_PC;
        m_out  = 0;
        m_drop = 0;
    endtask

    task automatic compare();
        chk("out_valid", out_valid, q_pc.size() != 0);
        if (q_pc.size() != 0) begin
            chk("out_pc", out_pc, q_pc[0]);
            chk("out_instr", out_instr, q_data[0]);
        end
        if (mem_req) begin
            chk("mem_addr", mem_addr, exp_pc);
            chk("req_while_outstanding", m_out, 0);
            chk("req_without_space", q_pc.size() < DEPTH, 1);
        end
    endtask

    task automatic step();
        bit          rv;
        bit          gn;
        logic [31:0] rd;
        compare();
        rv = (mem_pend && mem_wait == 0) || stray_rv;
        rd = mem_pend ? (mem_pend_addr ^ 32'hFFFF_FFFF) : 32'hDEAD_BEEF;
        gn = gnt_en && mem_req;
        mem_gnt    = gn;
        mem_rvalid = rv;
        mem_rdata  = rd;
        if (out_valid && out_ready) begin
            pop_log.push_back(out_pc);
            pop_data_log.push_back(out_instr);
            pop_cyc.push_back(cyc);
        end
        if (gn) gnt_log.push_back(mem_addr);
        if (mem_pend) begin
            if (mem_wait == 0) mem_pend = 0;
            else mem_wait--;
        end
        if (gn) begin
            mem_pend      = 1;
            mem_wait      = lat - 1;
            mem_pend_addr = mem_addr;
        end
        if (reset) begin
            if (q_pc.size() != 0 && out_ready) begin
                void'(q_pc.pop_front());
                void'(q_data.pop_front());
            end
            if (rv && m_out) begin
                if (!m_drop && !redirect) begin
                    q_pc.push_back(m_addr);
                    q_data.push_back(rd);
                end
                m_out = 0;
            end
            if (gn) begin
                m_out  = 1;
                m_drop = 0;
                m_addr = exp_pc;
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect) begin
                q_pc.delete();
                q_data.delete();
                if (m_out) m_drop = 1;
                exp_pc = redirect_pc & ~32'h3;
            end
        end else begin
            model_reset();
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect = 1'b0;
        stray_rv = 0;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        pop_data_log.delete();
        pop_cyc.delete();
        gnt_log.delete();
    endtask

    task automatic run_until_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, pop_log.size() >= n, 1);
    endtask

    task automatic run_until_gnts(input int n, input int budget, input string name);
        int k = 0;
        while (gnt_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, gnt_log.size() >= n, 1);
    endtask

    initial begin
        bit found;
        gnt_en = 0; lat = 1; mem_pend = 0; mem_wait = 0; stray_rv = 0;
        mem_pend_addr = '0; m_addr = '0;
        model_reset();
        clear_logs();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 32'h0000_3000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait memory, core always ready
        gnt_en = 1; lat = 1; out_ready = 1'b1;
        step();
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 32'h0000_3000);
        run_until_pops(4, 30, "s1_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("s1_pc", at(pop_log, i), s1_pc[i]);
            chk("s1_data", at(pop_data_log, i), s1_data[i]);
        end
        for (int i = 0; i < 3 && i + 1 < pop_cyc.size(); i++)
            chk("s1_spacing", pop_cyc[i+1] - pop_cyc[i], 2);

        // Core stalls: the queue fills to DEPTH and fetching stops
        out_ready = 1'b0;
        repeat (20) step();
        chk("s2_mem_req", mem_req, 0);
        chk("s2_out_valid", out_valid, 1);
        gnt_en = 0; out_ready = 1'b1;
        clear_logs();
        repeat (8) step();
        chk("s2_drain_count", pop_log.size(), 4);
        for (int i = 0; i < 3; i++)
            chk("s2_drain_seq", at(pop_log, i + 1) - at(pop_log, i), 4);

        // Redirect while waiting; stale response arrives 3 cycles later
        gnt_en = 1; lat = 4;
        clear_logs();
        run_until_gnts(1, 10, "s3_gnt_timeout");
        redirect = 1'b1; redirect_pc = 32'h0000_4001;
        clear_logs();
        step();
        chk("s3_valid_after_redirect", out_valid, 0);
        run_until_pops(1, 40, "s3_timeout");
        chk("s3_first_gnt", at(gnt_log, 0), 32'h0000_4000);
        chk("s3_first_pc", at(pop_log, 0), 32'h0000_4000);
        chk("s3_first_instr", at(pop_data_log, 0), 32'hFFFF_BFFF);

        // Redirect coincides with a response while two entries are buffered
        lat = 2; out_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (q_pc.size() == 2 && mem_pend && mem_wait == 0) begin
                found = 1;
                redirect = 1'b1;
                redirect_pc = 32'h0000_5000;
            end
            step();
        end
        chk("s4_setup", found, 1);
        chk("s4_valid_after_redirect", out_valid, 0);
        out_ready = 1'b1;
        clear_logs();
        run_until_pops(1, 40, "s4_timeout");
        chk("s4_first_pc", at(pop_log, 0), 32'h0000_5000);

        // Address wrap past the top of memory
        lat = 1;
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        clear_logs();
        run_until_pops(2, 40, "s5_timeout");
        chk("s5_gnt0", at(gnt_log, 0), 32'hFFFF_FFFC);
        chk("s5_gnt1", at(gnt_log, 1), 32'h0000_0000);
        chk("s5_pc0", at(pop_log, 0), 32'hFFFF_FFFC);
        chk("s5_pc1", at(pop_log, 1), 32'h0000_0000);
        chk("s5_data0", at(pop_data_log, 0), 32'h0000_0003);
        chk("s5_data1", at(pop_data_log, 1), 32'hFFFF_FFFF);

        // Reset asserted mid-transaction with entries buffered
        lat = 4; out_ready = 1'b0;
        clear_logs();
        run_until_gnts(2, 30, "s6_gnt_timeout");
        reset = 1'b0;
        #1;
        chk("s6_rst_mem_req", mem_req, 0);
        chk("s6_rst_mem_addr", mem_addr, 32'h0000_3000);
        chk("s6_rst_out_valid", out_valid, 0);
        chk("s6_rst_out_instr", out_instr, 0);
        chk("s6_rst_out_pc", out_pc, 0);
        gnt_en = 0;
        model_reset();
        stray_rv = 1;
        step();
        step();
        reset = 1'b1;
        repeat (3) step();
        stray_rv = 1;
        repeat (2) step();
        chk("s6_no_valid", out_valid, 0);
        gnt_en = 1; lat = 1; out_ready = 1'b1;
        clear_logs();
        run_until_pops(1, 20, "s6_timeout");
        chk("s6_first_gnt", at(gnt_log, 0), 32'h0000_3000);
        chk("s6_first_pc", at(pop_log, 0), 32'h0000_3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
